// File: rtl/osd_stm_trace_capture_pkg.sv
// Shared definitions for the software trace capture path: marker constants,
// the event record and the saturating counter step used by trace blocks.
package osd_stm_pkg;

  localparam logic [31:0] STM_MARKER_MASK  = 32'hffff0000;
  localparam logic [31:0] STM_MARKER_MATCH = 32'h15000000;
  localparam int          STM_ID_W         = 16;
  localparam int          STM_VALUE_W      = 64;

  typedef struct packed {
    logic [15:0] id;
    logic [63:0] value;
  } stm_event_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hffffffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/osd_stm_trace_capture_if.sv
// Core-side retirement/writeback inputs and STM-side trace outputs of the
// trace capture block, bundled so the core tile can route them as one port.
interface osd_stm_trace_capture_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      enable;
  logic                      retire_valid;
  logic [31:0]               retire_insn;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [XLEN-1:0]           wb_data;

  logic                      trace_valid;
  logic [15:0]               trace_id;
  logic [63:0]               trace_value;
  logic [31:0]               event_count;
  logic [31:0]               drop_count;

  modport master (
    output enable, retire_valid, retire_insn, wb_valid, wb_addr, wb_data,
    input  trace_valid, trace_id, trace_value, event_count, drop_count
  );

  modport slave (
    input  enable, retire_valid, retire_insn, wb_valid, wb_addr, wb_data,
    output trace_valid, trace_id, trace_value, event_count, drop_count
  );

endinterface

// File: rtl/osd_stm_trace_capture_shadow_regs.sv
// Shadow copies of the value-carrying registers with same-cycle writeback
// bypass; presents the assembled 64-bit payload combinationally.
module osd_stm_shadow_regs
  import osd_stm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int VALUE_REG_LO   = 3,
  parameter int VALUE_REG_HI   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [XLEN-1:0]           wb_data_i,
  output logic [STM_VALUE_W-1:0]    value_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] LO_ADDR = REG_ADDR_WIDTH'(VALUE_REG_LO);

  logic            lo_hit;
  logic [XLEN-1:0] shadow_lo_q;
  logic [XLEN-1:0] shadow_lo_d;
  logic [XLEN-1:0] lo_cur;

  // Register 0 is hardwired in the core, so a write aimed at it is never real.
  assign lo_hit      = wb_valid_i && (wb_addr_i == LO_ADDR) && (VALUE_REG_LO != 0);
  assign shadow_lo_d = lo_hit ? wb_data_i : shadow_lo_q;
  // The writeback seen alongside a marker is from an older instruction.
  assign lo_cur      = shadow_lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_lo_q <= '0;
    end else begin
      shadow_lo_q <= shadow_lo_d;
    end
  end

  if (XLEN == 32) begin : g_rv32
    localparam logic [REG_ADDR_WIDTH-1:0] HI_ADDR = REG_ADDR_WIDTH'(VALUE_REG_HI);

    logic            hi_hit;
    logic [XLEN-1:0] shadow_hi_q;
    logic [XLEN-1:0] shadow_hi_d;

    assign hi_hit      = wb_valid_i && (wb_addr_i == HI_ADDR) && (VALUE_REG_HI != 0);
    assign shadow_hi_d = hi_hit ? wb_data_i : shadow_hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_hi_q <= '0;
      end else begin
        shadow_hi_q <= shadow_hi_d;
      end
    end

    assign value_o = {shadow_hi_d, lo_cur};
  end else begin : g_rv64
    assign value_o = lo_cur;
  end

endmodule

// File: rtl/osd_stm_trace_capture.sv
// Detects retiring trace markers and registers one id/value event per marker
// for the STM debug module, with saturating event and drop counters.
module osd_stm_trace_capture
  import osd_stm_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter int          VALUE_REG_LO   = 3,
  parameter int          VALUE_REG_HI   = 4,
  parameter logic [31:0] MARKER_MASK    = STM_MARKER_MASK,
  parameter logic [31:0] MARKER_MATCH   = STM_MARKER_MATCH
) (
  input logic                    clk,
  input logic                    rst_n,
  osd_stm_trace_capture_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("osd_stm_trace_capture: XLEN must be 32 or 64");
  end

  if (XLEN == 32 && VALUE_REG_LO == VALUE_REG_HI) begin : g_bad_regs
    $error("osd_stm_trace_capture: VALUE_REG_LO and VALUE_REG_HI must differ");
  end

  logic [STM_VALUE_W-1:0] value;
  logic                   is_marker;

  osd_stm_shadow_regs #(
    .XLEN           (XLEN),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .VALUE_REG_LO   (VALUE_REG_LO),
    .VALUE_REG_HI   (VALUE_REG_HI)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid_i (bus.wb_valid),
    .wb_addr_i  (bus.wb_addr),
    .wb_data_i  (bus.wb_data),
    .value_o    (value)
  );

  // Id 0 is the plain nop encoding and never counts as a marker.
  assign is_marker = bus.retire_valid
                  && ((bus.retire_insn & MARKER_MASK) == MARKER_MATCH)
                  && (bus.retire_insn[15:0] != 16'h0000);

  logic        trace_valid_q, trace_valid_d;
  stm_event_t  ev_q, ev_d;
  logic [31:0] event_count_q, event_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    trace_valid_d = 1'b0;
    ev_d          = ev_q;
    event_count_d = event_count_q;
    drop_count_d  = drop_count_q;
    if (is_marker) begin
      if (bus.enable) begin
        trace_valid_d = 1'b1;
        ev_d.id       = bus.retire_insn[15:0];
        ev_d.value    = value;
        event_count_d = sat_inc32(event_count_q);
      end else begin
        drop_count_d  = sat_inc32(drop_count_q);
      end
    end
  end

  // Retirement cycle N -> event/counter register, visible in cycle N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid_q <= 1'b0;
      ev_q          <= '0;
      event_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      ev_q          <= ev_d;
      event_count_q <= event_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_id    = ev_q.id;
  assign bus.trace_value = ev_q.value;
  assign bus.event_count = event_count_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_osd_stm_trace_capture.sv
// Bench for osd_stm_trace_capture: directed vector table, multi-cycle corner
// sequences, and random traffic against an architectural register-file model.
module tb_osd_stm_trace_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  osd_stm_trace_capture_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus32 ();
  osd_stm_trace_capture_if #(.XLEN(64), .REG_ADDR_WIDTH(5)) bus64 ();

  osd_stm_trace_capture #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  osd_stm_trace_capture #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct {
    logic        en;
    logic        rv;
    logic [31:0] insn;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ev;
    logic [15:0] id;
    logic [63:0] val;
    logic [31:0] ec;
    logic [31:0] dc;
  } vec_t;

  vec_t tbl[$];

  // Reference model: architectural registers plus the event stream rules.
  logic [31:0] m_regs[32];
  logic        m_valid;
  logic [15:0] m_id;
  logic [63:0] m_val;
  logic [31:0] m_ec, m_dc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic en, input logic rv, input logic [31:0] insn,
                         input logic wv, input logic [4:0] wa, input logic [31:0] wd);
    bus32.enable       = en;
    bus32.retire_valid = rv;
    bus32.retire_insn  = insn;
    bus32.wb_valid     = wv;
    bus32.wb_addr      = wa;
    bus32.wb_data      = wd;
  endtask

  task automatic drive64(input logic en, input logic rv, input logic [31:0] insn,
                         input logic wv, input logic [4:0] wa, input logic [63:0] wd);
    bus64.enable       = en;
    bus64.retire_valid = rv;
    bus64.retire_insn  = insn;
    bus64.wb_valid     = wv;
    bus64.wb_addr      = wa;
    bus64.wb_data      = wd;
  endtask

  task automatic check32(input string tag, input logic v, input logic [15:0] id,
                         input logic [63:0] val, input logic [31:0] ec, input logic [31:0] dc);
    chk({tag, ".valid"}, {63'd0, bus32.trace_valid}, {63'd0, v});
    chk({tag, ".id"},    {48'd0, bus32.trace_id},    {48'd0, id});
    chk({tag, ".value"}, bus32.trace_value,          val);
    chk({tag, ".evcnt"}, {32'd0, bus32.event_count}, {32'd0, ec});
    chk({tag, ".drcnt"}, {32'd0, bus32.drop_count},  {32'd0, dc});
  endtask

  function automatic logic [31:0] sat(input logic [31:0] c);
    logic [32:0] w;
    w = {1'b0, c} + 33'd1;
    return w[32] ? 32'hffffffff : w[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid = 1'b0; m_id = '0; m_val = '0; m_ec = '0; m_dc = '0;
  endtask

  task automatic model_step(input logic en, input logic rv, input logic [31:0] insn,
                            input logic wv, input logic [4:0] wa, input logic [31:0] wd);
    logic mk;
    if (wv && wa != 5'd0) m_regs[wa] = wd;
    mk = rv && ((insn & 32'hffff0000) == 32'h15000000) && (insn[15:0] != 16'h0);
    m_valid = mk && en;
    if (mk && en) begin
      m_id  = insn[15:0];
      m_val = {m_regs[4], m_regs[3]};
      m_ec  = sat(m_ec);
    end else if (mk) begin
      m_dc  = sat(m_dc);
    end
  endtask

  task automatic add(input logic en, input logic rv, input logic [31:0] insn,
                     input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ev, input logic [15:0] id, input logic [63:0] val,
                     input logic [31:0] ec, input logic [31:0] dc);
    vec_t t;
    t.en = en; t.rv = rv; t.insn = insn; t.wv = wv; t.wa = wa; t.wd = wd;
    t.ev = ev; t.id = id; t.val = val; t.ec = ec; t.dc = dc;
    tbl.push_back(t);
  endtask

  initial begin
    logic [63:0] v_basic, v_byp;
    v_basic = 64'h3333_4444_1111_2222;
    v_byp   = 64'h3333_4444_dead_beef;

    //   en rv insn           wv wa     wd              ev id       value    evc dropc
    add(1, 0, 32'h0,          1, 5'd3, 32'h1111_2222,   0, 16'h0,  64'h0,   0, 0);
    add(1, 0, 32'h0,          1, 5'd4, 32'h3333_4444,   0, 16'h0,  64'h0,   0, 0);
    add(1, 1, 32'h1500_0042,  0, 5'd0, 32'h0,           1, 16'h42, v_basic, 1, 0);
    add(1, 0, 32'h0,          0, 5'd0, 32'h0,           0, 16'h42, v_basic, 1, 0);
    add(1, 1, 32'h1500_0007,  1, 5'd3, 32'hdead_beef,   1, 16'h07, v_byp,   2, 0);
    add(1, 1, 32'h1500_0001,  0, 5'd0, 32'h0,           1, 16'h01, v_byp,   3, 0);
    add(1, 1, 32'h1500_0002,  0, 5'd0, 32'h0,           1, 16'h02, v_byp,   4, 0);
    add(1, 1, 32'h1500_0003,  0, 5'd0, 32'h0,           1, 16'h03, v_byp,   5, 0);
    add(1, 1, 32'h1500_0000,  0, 5'd0, 32'h0,           0, 16'h03, v_byp,   5, 0);
    add(1, 1, 32'h1400_0005,  0, 5'd0, 32'h0,           0, 16'h03, v_byp,   5, 0);
    add(0, 1, 32'h1500_0009,  0, 5'd0, 32'h0,           0, 16'h03, v_byp,   5, 1);
    add(1, 0, 32'h1500_0011,  0, 5'd0, 32'h0,           0, 16'h03, v_byp,   5, 1);
    add(1, 1, 32'h1500_0012,  1, 5'd5, 32'hffff_ffff,   1, 16'h12, v_byp,   6, 1);
    add(1, 1, 32'h1500_0013,  0, 5'd0, 32'h0,           1, 16'h13, v_byp,   7, 1);
    add(0, 0, 32'h0,          1, 5'd0, 32'h5555_5555,   0, 16'h13, v_byp,   7, 1);
    add(1, 1, 32'h1500_0014,  1, 5'd4, 32'haaaa_0000,   1, 16'h14, 64'haaaa_0000_dead_beef, 8, 1);

    rst_n = 1'b0;
    drive32(0, 0, 32'h0, 0, 5'd0, 32'h0);
    drive64(0, 0, 32'h0, 0, 5'd0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check32("reset", 1'b0, 16'h0, 64'h0, 32'h0, 32'h0);
    chk("reset64.value", bus64.trace_value, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive32(tbl[i].en, tbl[i].rv, tbl[i].insn, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      tick();
      check32($sformatf("vec%0d", i), tbl[i].ev, tbl[i].id, tbl[i].val, tbl[i].ec, tbl[i].dc);
    end

    // Reset asserted inside the strobe cycle clears everything at once.
    drive32(1, 1, 32'h1500_0021, 0, 5'd0, 32'h0);
    tick();
    chk("rst_pre.valid", {63'd0, bus32.trace_valid}, 64'd1);
    drive32(0, 0, 32'h0, 0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check32("rst_mid", 1'b0, 16'h0, 64'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive32(1, 1, 32'h1500_0022, 0, 5'd0, 32'h0);
    model_reset();
    model_step(1, 1, 32'h1500_0022, 0, 5'd0, 32'h0);
    tick();
    check32("rst_post", 1'b1, 16'h22, 64'h0, 32'h1, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic en, rv, wv;
      logic [31:0] insn, wd;
      logic [4:0] wa;
      en = ($urandom_range(0, 7) != 0);
      rv = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: insn = 32'h1500_0000 | 32'($urandom_range(1, 20));
        1: insn = 32'h1500_0000;
        2: insn = $urandom();
        default: insn = 32'h1500_0000 | 32'($urandom_range(0, 65535));
      endcase
      wv = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 6));
      wd = $urandom();
      drive32(en, rv, insn, wv, wa, wd);
      model_step(en, rv, insn, wv, wa, wd);
      tick();
      check32($sformatf("rnd%0d", n), m_valid, m_id, m_val, m_ec, m_dc);
    end

    // Pin both counters at all-ones across an edge, then keep retiring markers.
    drive32(1, 1, 32'h1500_0031, 0, 5'd0, 32'h0);
    force dut32.event_count_q = 32'hffffffff;
    force dut32.drop_count_q  = 32'hffffffff;
    m_ec = 32'hffffffff;
    m_dc = 32'hffffffff;
    model_step(1, 1, 32'h1500_0031, 0, 5'd0, 32'h0);
    tick();
    release dut32.event_count_q;
    release dut32.drop_count_q;
    drive32(1, 1, 32'h1500_0032, 0, 5'd0, 32'h0);
    model_step(1, 1, 32'h1500_0032, 0, 5'd0, 32'h0);
    tick();
    check32("sat_ev", m_valid, m_id, m_val, m_ec, m_dc);
    chk("sat_ev.hold", {32'd0, bus32.event_count}, 64'h0000_0000_ffff_ffff);
    drive32(0, 1, 32'h1500_0033, 0, 5'd0, 32'h0);
    model_step(0, 1, 32'h1500_0033, 0, 5'd0, 32'h0);
    tick();
    check32("sat_dr", m_valid, m_id, m_val, m_ec, m_dc);
    chk("sat_dr.hold", {32'd0, bus32.drop_count}, 64'h0000_0000_ffff_ffff);
    drive32(0, 0, 32'h0, 0, 5'd0, 32'h0);

    drive64(1, 0, 32'h0, 1, 5'd3, 64'h0123_4567_89ab_cdef);
    tick();
    drive64(1, 1, 32'h1500_0064, 0, 5'd0, 64'h0);
    tick();
    chk("x64.valid", {63'd0, bus64.trace_valid}, 64'd1);
    chk("x64.id",    {48'd0, bus64.trace_id},    64'h64);
    chk("x64.value", bus64.trace_value,          64'h0123_4567_89ab_cdef);
    chk("x64.evcnt", {32'd0, bus64.event_count}, 64'd1);
    drive64(1, 1, 32'h1500_0065, 1, 5'd4, 64'hffff_ffff_ffff_ffff);
    tick();
    chk("x64_hi.value", bus64.trace_value, 64'h0123_4567_89ab_cdef);
    drive64(1, 1, 32'h1500_0066, 1, 5'd3, 64'hfedc_ba98_7654_3210);
    tick();
    chk("x64_byp.value", bus64.trace_value,          64'hfedc_ba98_7654_3210);
    chk("x64_byp.evcnt", {32'd0, bus64.event_count}, 64'd3);
    drive64(1, 0, 32'h0, 0, 5'd0, 64'h0);
    tick();
    chk("x64_idle.valid", {63'd0, bus64.trace_valid}, 64'd0);
    chk("x64_idle.value", bus64.trace_value,          64'hfedc_ba98_7654_3210);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osd_stm_trace_capture.md
# osd_stm_trace_capture

CPU-side front end of the software trace module. It watches the core's retirement and register-writeback ports and detects trace marker instructions. It keeps shadow copies of the registers that carry the trace value and emits one `trace_valid`/`trace_id`/`trace_value` event per retired marker. Those three outputs connect directly to the trace inputs of the STM debug module in the same core tile.

## Interface
Parameters:
- `XLEN`, 32: core register width; legal values 32 or 64.
- `REG_ADDR_WIDTH`, 5: register-file address width.
- `VALUE_REG_LO`, 3: register carrying the value (low half when XLEN=32).
- `VALUE_REG_HI`, 4: register carrying value[63:32]; ignored when XLEN=64.
- `MARKER_MASK`, 32'hffff0000: bits of `retire_insn` compared for marker detection.
- `MARKER_MATCH`, 32'h15000000: required value of the masked bits.

Ports:
- `clk`  in  1  the single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable; typically driven from the STM control register.
- `retire_valid`  in  1  one instruction retires this cycle.
- `retire_insn`  in  32  encoding of the retiring instruction.
- `wb_valid`  in  1  register write this cycle.
- `wb_addr`  in  REG_ADDR_WIDTH  destination register.
- `wb_data`  in  XLEN  write data.
- `trace_valid`  out  1  single-cycle event strobe.
- `trace_id`  out  16  event identifier, equal to `retire_insn[15:0]`.
- `trace_value`  out  64  event payload.
- `event_count`  out  32  number of events emitted; saturating.
- `drop_count`  out  32  number of markers seen while `enable`=0; saturating.

## Operation
- **Shadow registers.** `shadow_lo` and `shadow_hi` are each XLEN wide.
  - `wb_valid && wb_addr==VALUE_REG_LO` loads `shadow_lo`.
  - The same rule with `VALUE_REG_HI` loads `shadow_hi`, only when XLEN=32.
  - Writes to register 0 are never shadowed, even if a parameter names it.
- **Marker detection.** A retiring instruction is a marker when all of these hold:
  - `retire_valid` is 1;
  - `(retire_insn & MARKER_MASK) == MARKER_MATCH`;
  - `retire_insn[15:0] != 0` (id 0 is a plain nop and is ignored entirely).
- **Value assembly** (bypass applies to both cases):
  - XLEN=32: `{hi, lo}`.
  - XLEN=64: `lo`.
  - A writeback presented in the same cycle as a marker retirement belongs to an older instruction. The new `wb_data` is therefore used in place of the shadow value.
- **Enable = 1.** A marker registers the event and increments `event_count`.
- **Enable = 0.** A marker produces no event and increments `drop_count`. The shadow registers keep updating regardless of `enable`.
- **Counters** saturate at 32'hffffffff and never wrap.
- **No backpressure.** The downstream sampler absorbs every strobe, so this block never stalls or queues.

## Timing
- **Latency.** A marker retiring in cycle N produces `trace_valid`=1 in cycle N+1, with `trace_id` and `trace_value` valid in that same cycle.
- **Strobe width.** `trace_valid` is high for exactly one cycle per marker.
- **Throughput.** Markers on consecutive cycles give consecutive strobes; one event per cycle is sustained.
- **Output hold.** `trace_id` and `trace_value` keep their last value while `trace_valid`=0.
- **Counters** update in cycle N+1, in the same cycle as the strobe.
- **Enable sampling.** `enable` is sampled in the retirement cycle N. Deasserting it in N+1 does not cancel the strobe for N.
- **Reset.** Asynchronous assertion of `rst_n` clears immediately:
  - `trace_valid`=0, `trace_id`=0, `trace_value`=0;
  - both shadows to 0;
  - both counters to 0.
  - A marker retiring in the cycle reset deasserts is captured normally.
  - Reset asserted in cycle N+1 suppresses the pending strobe.
- **Boundary cases.**
  - A write to a shadowed register in cycle N+1 does not alter an event already registered.
  - `wb_valid` with `VALUE_REG_LO==VALUE_REG_HI` is a parameter error; flag it with an elaboration-time assertion.

## Structure
- Package `osd_stm_pkg` holds:
  - the default marker constants (`STM_MARKER_MASK`, `STM_MARKER_MATCH`);
  - `typedef struct packed { logic [15:0] id; logic [63:0] value; } stm_event_t`;
  - the saturating-increment function shared with other trace blocks.
- One sub-module, `osd_stm_shadow_regs`, owns the shadow registers and the same-cycle bypass and presents the assembled 64-bit value. Marker decode, output register and counters stay in the top module.

## Test plan
- **Basic event.** Write 32'h1111_2222 to r3 and 32'h3333_4444 to r4, then retire 32'h1500_0042 with `enable`=1. Expect a single strobe one cycle later with id 16'h0042, value 64'h3333_4444_1111_2222 and `event_count`=1.
- **Same-cycle bypass.** Write 32'hdead_beef to r3 in the same cycle as marker 32'h1500_0007. Expect value[31:0]=32'hdead_beef, not the old shadow.
- **Back-to-back.** Retire markers 0x0001, 0x0002 and 0x0003 on consecutive cycles. Expect three consecutive strobes with matching ids and `event_count`=3.
- **Filtering and drops.**
  - Retire 32'h1500_0000 (id 0) and a non-marker 32'h1400_0005. Expect no strobe and no counter change.
  - With `enable`=0, retire marker 0x0009. Expect no strobe and `drop_count`=1.
- **Reset mid-operation.** Assert `rst_n`=0 in the strobe cycle. Expect all outputs and shadows 0 immediately. After release, a marker yields value 64'h0 unless the value registers were rewritten.
- **Saturation and XLEN=64.**
  - Force `event_count` near 32'hffffffff and retire two markers. Expect the count to hold at 32'hffffffff.
  - With XLEN=64, write 64'h0123_4567_89ab_cdef to r3. Expect exactly that value in the event.
